song_sequencer: RTL
===================

# song_sequencer

Beat and note scheduler for a play session of the game. It watches the 3-bit `mode` from `state_fsm` and latches the difficulty when RUN starts. It then generates beat pulses at a tempo set by that difficulty, runs a lead-in count, and steps the song-ROM note address. When the song ends it asserts `fin_check` back to `state_fsm`. It freezes cleanly in PAUSE, and it aborts or clears when `mode` leaves RUN/PAUSE.

## Interface
- `SONG_LEN`, default 64: number of notes; legal range 2..256.
- `ADDR_W`, default 8: `note_addr` width; `2^ADDR_W >= SONG_LEN`.
- `LEAD_BEATS`, default 4: count-in beats before the first note; legal range 1..7.
- `BEAT_EASY`, default 6_000_000: beat period in clk cycles for difficulty 0; legal minimum 2.
- `BEAT_MED`, default 4_000_000: beat period for difficulty 1; legal minimum 2.
- `BEAT_HARD`, default 3_000_000: beat period for difficulty 2 and 3; legal minimum 2.
- `clk` input, 1 bit: 12 MHz system clock; all logic is on the rising edge.
- `rst` input, 1 bit: synchronous reset, active-high.
- `mode` input, 3 bits: `state_fsm` mode. Encoding: 1 IDLE, 2 EDIT, 3 DIFF, 4 RUN, 5 PAUSE, 6 FINISH. Values 0 and 7 are treated as IDLE.
- `diff_sel` input, 2 bits: difficulty selected in DIFF mode.
- `note_addr` output, ADDR_W bits: song-ROM address of the current note.
- `beat_pulse` output, 1 bit: one-cycle strobe on every beat, including count-in beats.
- `count_in` output, 3 bits: remaining lead-in beats, for display.
- `playing` output, 1 bit: high while in PLAY.
- `fin_check` output, 1 bit: song completed; level signal to `state_fsm`.

## Operation
- States:
  - S_IDLE
  - S_COUNTIN
  - S_PLAY
  - S_HOLD, which keeps a saved return state of COUNTIN or PLAY
  - S_DONE
- Reset (highest priority): state S_IDLE, `tick_cnt` 0. All outputs are 0 (`note_addr` 0, `count_in` 0).
- Beat event: `tick_cnt == period-1` while in S_COUNTIN or S_PLAY with `mode == RUN`.
  - On a beat event, `tick_cnt` goes to 0 and `beat_pulse` is registered high for the next cycle.
  - Otherwise, `tick_cnt` increments in S_COUNTIN/S_PLAY, holds in S_HOLD, and clears in every other state.
- S_IDLE:
  - `mode == RUN`: latch `period` from `diff_sel` (0 gives BEAT_EASY, 1 gives BEAT_MED, 2 or 3 gives BEAT_HARD). Load `count_in = LEAD_BEATS`, set `note_addr` 0, `tick_cnt` 0, and go to S_COUNTIN.
  - Other modes: stay in S_IDLE.
- S_COUNTIN: each beat decrements `count_in`. The beat that takes `count_in` from 1 to 0 moves to S_PLAY with `note_addr` 0.
- S_PLAY: on each beat, either `note_addr` increments, or, if `note_addr == SONG_LEN-1`, go to S_DONE with `fin_check` set to 1.
- Pause: `mode == PAUSE` in S_COUNTIN/S_PLAY saves the return state and goes to S_HOLD. `tick_cnt`, `count_in` and `note_addr` are frozen.
- S_HOLD exits:
  - `mode == RUN` returns to the saved state; `tick_cnt` resumes from its frozen value.
  - `mode == FINISH` goes to S_DONE as an abort; `fin_check` stays 0.
- Abort from active states: `mode == FINISH` in S_COUNTIN/S_PLAY goes to S_DONE with `fin_check` 0.
- Clear: `mode` in {IDLE, EDIT, DIFF, 0, 7} in any non-IDLE state goes to S_IDLE and clears `note_addr`, `count_in`, `fin_check` and `tick_cnt`.
- S_DONE:
  - `fin_check` holds while `mode` is RUN or FINISH.
  - Any other mode clears `fin_check` and goes to S_IDLE.
- `playing` is 1 exactly when the state is S_PLAY.
- `diff_sel` changes outside the S_IDLE-to-S_COUNTIN transition are ignored.

## Timing
- Enter S_COUNTIN at edge N.
  - The first `beat_pulse` is high in the cycle after edge N+period.
  - Later pulses come every `period` cycles.
  - `count_in`, `note_addr` and state update on the same edge that raises `beat_pulse`.
- Song length: `fin_check` rises `(LEAD_BEATS+SONG_LEN)*period` cycles after entry to S_COUNTIN, on the same edge as the last `beat_pulse`.
- Pause and beat in the same cycle: pause wins. The beat is suppressed and `tick_cnt` holds at period-1, so the beat fires on the first RUN cycle after resume.
- Cycles spent in S_HOLD do not advance the beat.
- `mode` leaving RUN during the `beat_pulse` cycle does not cancel the pulse already registered.
- Reset asserted mid-operation returns to the reset values on the next edge, regardless of `mode`.

## Test plan
Parameters for all scenarios: BEAT_EASY=8, BEAT_MED=6, BEAT_HARD=4, SONG_LEN=4, LEAD_BEATS=2. Cycle counts are measured from entry to S_COUNTIN.
1. Reset: hold `rst` with `mode=RUN` -> all outputs 0 and state S_IDLE; release with `mode=IDLE` -> outputs remain 0.
2. Hard song:
   - Stimulus: `diff_sel=2`, `mode=RUN`.
   - Pulses: `beat_pulse` after cycles 4, 8, 12, 16, 20 and 24.
   - Count-in: `count_in` goes 2→1→0, and `playing` rises at cycle 8.
   - Notes: `note_addr` reads 0, 1, 2, 3.
   - Finish: `fin_check`=1 at cycle 24. Switching `mode` to FINISH keeps it 1; then `mode=IDLE` gives `fin_check`=0.
3. Pause:
   - Stimulus: easy period; set `mode=PAUSE` for 20 cycles at cycle 13 (`tick_cnt`=5), then return to RUN.
   - Response: no `beat_pulse`, and `note_addr` stays 0, during the pause. The next pulse comes 3 cycles after resume (at the `tick_cnt`=7 beat).
4. Abort: PAUSE then FINISH mid-song -> S_DONE with `fin_check`=0; then `mode=IDLE` -> S_IDLE with `note_addr`=0.
5. Clear mid-run: `mode=EDIT` at `note_addr`=2 -> next cycle `note_addr`=0, `count_in`=0, `playing`=0; a new RUN restarts the count-in at 2.
6. Difficulty latch: start with `diff_sel=0` and change it to 2 after entry -> pulses stay 8 cycles apart; `diff_sel=3` on the next run gives a 4-cycle period.

Source files
------------

// File: rtl/song_sequencer.sv
// Beat and note scheduler for one play session: count-in, tempo-driven note stepping,
// pause/resume with a frozen beat phase, abort and clear driven by the state_fsm mode.
module song_sequencer #(
    parameter int SONG_LEN   = 64,
    parameter int ADDR_W     = 8,
    parameter int LEAD_BEATS = 4,
    parameter int BEAT_EASY  = 6_000_000,
    parameter int BEAT_MED   = 4_000_000,
    parameter int BEAT_HARD  = 3_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        mode,
    input  logic [1:0]        diff_sel,
    output logic [ADDR_W-1:0] note_addr,
    output logic              beat_pulse,
    output logic [2:0]        count_in,
    output logic              playing,
    output logic              fin_check
);

    localparam int TICK_W = 32;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COUNTIN = 3'd1;
    localparam logic [2:0] S_PLAY    = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [2:0] M_RUN    = 3'd4;
    localparam logic [2:0] M_PAUSE  = 3'd5;
    localparam logic [2:0] M_FINISH = 3'd6;

    localparam logic [ADDR_W-1:0] LAST_NOTE = ADDR_W'(SONG_LEN - 1);

    logic [2:0]        state_reg, state_next;
    logic [2:0]        ret_reg, ret_next;
    logic [TICK_W-1:0] tick_reg, tick_next;
    logic [TICK_W-1:0] period_reg, period_next;
    logic [2:0]        count_reg, count_next;
    logic [ADDR_W-1:0] note_reg, note_next;
    logic              fin_reg, fin_next;
    logic              beat_reg;
    logic              beat_event;

    logic is_run, is_pause, is_finish;
    assign is_run    = (mode == M_RUN);
    assign is_pause  = (mode == M_PAUSE);
    assign is_finish = (mode == M_FINISH);

    // Difficulty codes 2 and 3 share the hard tempo.
    logic [TICK_W-1:0] period_lut [4];
    for (genvar gi = 0; gi < 4; gi++) begin : g_period_lut
        localparam int PERIOD = (gi == 0) ? BEAT_EASY : (gi == 1) ? BEAT_MED : BEAT_HARD;
        assign period_lut[gi] = TICK_W'(PERIOD);
    end

    always_comb begin
        state_next  = state_reg;
        ret_next    = ret_reg;
        tick_next   = tick_reg;
        period_next = period_reg;
        count_next  = count_reg;
        note_next   = note_reg;
        fin_next    = fin_reg;
        beat_event  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                tick_next = '0;
                if (is_run) begin
                    period_next = period_lut[diff_sel];
                    count_next  = 3'(LEAD_BEATS);
                    note_next   = '0;
                    state_next  = S_COUNTIN;
                end
            end
            S_COUNTIN, S_PLAY: begin
                if (is_run) begin
                    if (tick_reg == period_reg - TICK_W'(1)) begin
                        beat_event = 1'b1;
                        tick_next  = '0;
                        if (state_reg == S_COUNTIN) begin
                            count_next = count_reg - 3'd1;
                            if (count_reg == 3'd1) begin
                                state_next = S_PLAY;
                                note_next  = '0;
                            end
                        end else if (note_reg == LAST_NOTE) begin
                            state_next = S_DONE;
                            fin_next   = 1'b1;
                        end else begin
                            note_next = note_reg + ADDR_W'(1);
                        end
                    end else begin
                        tick_next = tick_reg + TICK_W'(1);
                    end
                end else if (is_pause) begin
                    // Pause takes precedence over a due beat; the tick stays at period-1.
                    ret_next   = state_reg;
                    state_next = S_HOLD;
                end else if (is_finish) begin
                    state_next = S_DONE;
                    tick_next  = '0;
                end else begin
                    state_next = S_IDLE;
                    tick_next  = '0;
                    count_next = '0;
                    note_next  = '0;
                    fin_next   = 1'b0;
                end
            end
            S_HOLD: begin
                if (is_run) begin
                    state_next = ret_reg;
                end else if (is_finish) begin
                    state_next = S_DONE;
                    tick_next  = '0;
                end else if (!is_pause) begin
                    state_next = S_IDLE;
                    tick_next  = '0;
                    count_next = '0;
                    note_next  = '0;
                    fin_next   = 1'b0;
                end
            end
            S_DONE: begin
                tick_next = '0;
                if (!(is_run || is_finish)) begin
                    state_next = S_IDLE;
                    count_next = '0;
                    note_next  = '0;
                    fin_next   = 1'b0;
                end
            end
            default: begin
                state_next = S_IDLE;
                tick_next  = '0;
                count_next = '0;
                note_next  = '0;
                fin_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            ret_reg    <= S_COUNTIN;
            tick_reg   <= '0;
            period_reg <= TICK_W'(BEAT_EASY);
            count_reg  <= '0;
            note_reg   <= '0;
            fin_reg    <= 1'b0;
            beat_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ret_reg    <= ret_next;
            tick_reg   <= tick_next;
            period_reg <= period_next;
            count_reg  <= count_next;
            note_reg   <= note_next;
            fin_reg    <= fin_next;
            beat_reg   <= beat_event;
        end
    end

    assign note_addr  = note_reg;
    assign beat_pulse = beat_reg;
    assign count_in   = count_reg;
    assign playing    = (state_reg == S_PLAY);
    assign fin_check  = fin_reg;

endmodule
